// File: rtl/srl_q1_pkg.sv
// Shared types for the srl_q1 latch model: input decode of an active-low SR pair.
package srl_q1_pkg;

   typedef enum logic [1:0] {
      SRL_HOLD   = 2'd0,
      SRL_SET    = 2'd1,
      SRL_RESET  = 2'd2,
      SRL_FORBID = 2'd3
   } srl_op_e;

   function automatic srl_op_e srl_decode(input logic set_n, input logic reset_n);
      srl_op_e op;
      unique case ({set_n, reset_n})
         2'b11:   op = SRL_HOLD;
         2'b01:   op = SRL_SET;
         2'b10:   op = SRL_RESET;
         default: op = SRL_FORBID;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/srl_q1_core.sv
// One clocked NAND SR latch with registered q/qb, forbidden flag and race-exit pulse.
module srl_q1_core
   import srl_q1_pkg::*;
#(
   parameter logic RESET_Q = 1'b1,
   parameter logic RACE_Q  = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic set_n_i,
   input  logic reset_n_i,
   output logic q_o,
   output logic qb_o,
   output logic inv_o,
   output logic race_o
);

   srl_op_e op;
   logic    q_q, q_d;
   logic    qb_q, qb_d;
   logic    inv_q, inv_d;
   logic    race_q, race_d;

   always_comb begin
      op     = srl_decode(set_n_i, reset_n_i);
      q_d    = q_q;
      qb_d   = qb_q;
      inv_d  = 1'b0;
      race_d = 1'b0;
      unique case (op)
         SRL_HOLD: begin
            // inv_q marks that the previous inputs were forbidden, so this hold is a race exit
            if (inv_q) begin
               q_d    = RACE_Q;
               qb_d   = ~RACE_Q;
               race_d = 1'b1;
            end
         end
         SRL_SET: begin
            q_d  = 1'b1;
            qb_d = 1'b0;
         end
         SRL_RESET: begin
            q_d  = 1'b0;
            qb_d = 1'b1;
         end
         SRL_FORBID: begin
            q_d   = 1'b1;
            qb_d  = 1'b1;
            inv_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q    <= RESET_Q;
         qb_q   <= ~RESET_Q;
         inv_q  <= 1'b0;
         race_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         qb_q   <= qb_d;
         inv_q  <= inv_d;
         race_q <= race_d;
      end
   end

   assign q_o    = q_q;
   assign qb_o   = qb_q;
   assign inv_o  = inv_q;
   assign race_o = race_q;

endmodule

// File: rtl/srl_q1.sv
// Two independent clocked NAND SR latches (2-input A, 3-input B).
// Optional sticky forbidden-state flag enabled by SRL_Q1_STICKY_ERR_EN.
module srl_q1
   import srl_q1_pkg::*;
#(
   parameter logic RESET_Q = 1'b1,
   parameter logic RACE_Q  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic s_n,
   input  logic r_n,
   input  logic s1_n,
   input  logic r1_n,
   input  logic s2_n,
   input  logic r2_n,
   output logic q2,
   output logic qb2,
   output logic q3,
   output logic qb3,
   output logic inv2,
   output logic inv3,
   output logic race2,
   output logic race3,
   output logic err_sticky
);

   logic b_set_n;
   logic b_reset_n;

   // A 3-input NAND latch asserts when any of its active-low inputs is low
   assign b_set_n   = s1_n & s2_n;
   assign b_reset_n = r1_n & r2_n;

   srl_q1_core #(
      .RESET_Q (RESET_Q),
      .RACE_Q  (RACE_Q)
   ) u_latch_a (
      .clk_i     (clk),
      .rst_i     (rst),
      .set_n_i   (s_n),
      .reset_n_i (r_n),
      .q_o       (q2),
      .qb_o      (qb2),
      .inv_o     (inv2),
      .race_o    (race2)
   );

   srl_q1_core #(
      .RESET_Q (RESET_Q),
      .RACE_Q  (RACE_Q)
   ) u_latch_b (
      .clk_i     (clk),
      .rst_i     (rst),
      .set_n_i   (b_set_n),
      .reset_n_i (b_reset_n),
      .q_o       (q3),
      .qb_o      (qb3),
      .inv_o     (inv3),
      .race_o    (race3)
   );

`ifdef SRL_Q1_STICKY_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q | inv2 | inv3;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_sticky = err_q;
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_srl_q1.sv
// Directed self-checking bench for srl_q1 with default RESET_Q=1, RACE_Q=0.
module tb_srl_q1;

`ifdef SRL_Q1_STICKY_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, s_n, r_n, s1_n, r1_n, s2_n, r2_n;
   logic q2, qb2, q3, qb3, inv2, inv3, race2, race3, err_sticky;
   int   n_cmp = 0;
   int   n_err = 0;
   logic seen;

   always #5 clk = ~clk;

   srl_q1 #(
      .RESET_Q (1'b1),
      .RACE_Q  (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_n        (s_n),
      .r_n        (r_n),
      .s1_n       (s1_n),
      .r1_n       (r1_n),
      .s2_n       (s2_n),
      .r2_n       (r2_n),
      .q2         (q2),
      .qb2        (qb2),
      .q3         (q3),
      .qb3        (qb3),
      .inv2       (inv2),
      .inv3       (inv3),
      .race2      (race2),
      .race3      (race3),
      .err_sticky (err_sticky)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic eq, input logic eqb,
                        input logic einv, input logic erace);
      chk({tag, ".q2"}, q2, eq);
      chk({tag, ".qb2"}, qb2, eqb);
      chk({tag, ".inv2"}, inv2, einv);
      chk({tag, ".race2"}, race2, erace);
   endtask

   task automatic chk_b(input string tag, input logic eq, input logic eqb,
                        input logic einv, input logic erace);
      chk({tag, ".q3"}, q3, eq);
      chk({tag, ".qb3"}, qb3, eqb);
      chk({tag, ".inv3"}, inv3, einv);
      chk({tag, ".race3"}, race3, erace);
   endtask

   // drive both latches with the same effective (set_n, reset_n), routed through B's inputs 1
   task automatic both(input logic sn, input logic rn);
      s_n = sn; r_n = rn;
      s1_n = sn; r1_n = rn; s2_n = 1'b1; r2_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      seen = 1'b0;
      rst = 1'b1;
      both(1'b0, 1'b1);
      tick();
      chk_a("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_b("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset.err", err_sticky, 1'b0);

      rst = 1'b0;
      both(1'b0, 1'b0);
      tick();
      chk_a("forbid", 1'b1, 1'b1, 1'b1, 1'b0);
      chk_b("forbid", 1'b1, 1'b1, 1'b1, 1'b0);
      chk("forbid.err", err_sticky, 1'b0);
      seen = 1'b1;

      both(1'b1, 1'b1);
      tick();
      chk_a("race", 1'b0, 1'b1, 1'b0, 1'b1);
      chk_b("race", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("race.err", err_sticky, ERR_EN & seen);

      tick();
      chk_a("race_end", 1'b0, 1'b1, 1'b0, 1'b0);

      both(1'b0, 1'b1);
      tick();
      chk_a("set", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_b("set", 1'b1, 1'b0, 1'b0, 1'b0);

      both(1'b1, 1'b0);
      tick();
      chk_a("reset_op", 1'b0, 1'b1, 1'b0, 1'b0);
      both(1'b1, 1'b1);
      tick();
      chk_a("hold0", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_b("hold0b", 1'b0, 1'b1, 1'b0, 1'b0);

      // latch B via second inputs; latch A holds at 0
      s1_n = 1'b1; s2_n = 1'b0; r1_n = 1'b1; r2_n = 1'b1;
      tick();
      chk_b("b_set2", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_a("a_hold", 1'b0, 1'b1, 1'b0, 1'b0);
      s2_n = 1'b1; r2_n = 1'b0;
      tick();
      chk_b("b_rst2", 1'b0, 1'b1, 1'b0, 1'b0);

      // B forbidden via mixed inputs, then direct set: no race
      s1_n = 1'b0; s2_n = 1'b1; r1_n = 1'b1; r2_n = 1'b0;
      tick();
      chk_b("b_forbid_mix", 1'b1, 1'b1, 1'b1, 1'b0);
      chk("a_inv_clear", inv2, 1'b0);
      s1_n = 1'b1; s2_n = 1'b0; r2_n = 1'b1;
      tick();
      chk_b("b_forbid_set", 1'b1, 1'b0, 1'b0, 1'b0);
      both(1'b0, 1'b0);
      tick();
      chk_a("f_then_r.f", 1'b1, 1'b1, 1'b1, 1'b0);
      both(1'b1, 1'b0);
      tick();
      chk_a("f_then_r.r", 1'b0, 1'b1, 1'b0, 1'b0);

      // full sequence 00,11,10,11,00,11,01 on both latches
      both(1'b0, 1'b0); tick();
      chk_a("seq0", 1'b1, 1'b1, 1'b1, 1'b0); chk_b("seq0", 1'b1, 1'b1, 1'b1, 1'b0);
      both(1'b1, 1'b1); tick();
      chk_a("seq1", 1'b0, 1'b1, 1'b0, 1'b1); chk_b("seq1", 1'b0, 1'b1, 1'b0, 1'b1);
      both(1'b1, 1'b0); tick();
      chk_a("seq2", 1'b0, 1'b1, 1'b0, 1'b0); chk_b("seq2", 1'b0, 1'b1, 1'b0, 1'b0);
      both(1'b1, 1'b1); tick();
      chk_a("seq3", 1'b0, 1'b1, 1'b0, 1'b0); chk_b("seq3", 1'b0, 1'b1, 1'b0, 1'b0);
      both(1'b0, 1'b0); tick();
      chk_a("seq4", 1'b1, 1'b1, 1'b1, 1'b0); chk_b("seq4", 1'b1, 1'b1, 1'b1, 1'b0);
      both(1'b1, 1'b1); tick();
      chk_a("seq5", 1'b0, 1'b1, 1'b0, 1'b1); chk_b("seq5", 1'b0, 1'b1, 1'b0, 1'b1);
      both(1'b0, 1'b1); tick();
      chk_a("seq6", 1'b1, 1'b0, 1'b0, 1'b0); chk_b("seq6", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("seq6.err", err_sticky, ERR_EN & seen);

      // reset clears everything, including the sticky flag
      rst = 1'b1;
      both(1'b1, 1'b0);
      tick();
      chk_a("rst2", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_b("rst2", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst2.err", err_sticky, 1'b0);
      rst = 1'b0;
      both(1'b1, 1'b1);
      tick();
      chk_a("post_rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst.err", err_sticky, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
